// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver (LSB first, idle high) with a valid/ready dequeue port.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_core #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int BAUD_DIV   = CLOCK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       io_rx,
    output logic       io_deq_valid,
    input  logic       io_deq_ready,
    output logic [7:0] io_deq_bits,
    output logic       io_frame_err,
    output logic       io_overrun,
    output logic       io_busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } state_e;

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             deliver_q;
    logic             frame_err_q;
    logic             busy_q;
    logic             overrun_q;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= io_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_s = rx_sync_q;

    // Deframing FSM: baud counter, bit index, shift register and framing pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        // A line that is high again at mid-start was only a glitch.
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                        if (rx_s) begin
                            state_q   <= ST_IDLE;
                            deliver_q <= 1'b1;
                        end else begin
                            state_q     <= ST_WAIT_IDLE;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_d;
    logic        empty_s;
    logic        full_s;
    logic        deq_s;
    logic        enq_s;

    // Occupancy from wrap-bit pointers; a full FIFO still accepts a byte when the head leaves.
    always_comb begin
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        deq_s    = !empty_s && io_deq_ready;
        enq_s    = deliver_q && (!full_s || deq_s);
        wr_ptr_d = enq_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = deq_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    // FIFO storage, pointers and overrun pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (enq_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= deliver_q && full_s && !deq_s;
        end
    end

    assign io_deq_valid = !empty_s;
    assign io_deq_bits  = mem_q[rd_ptr_q[AW-1:0]];
`else
    logic       hold_valid_q;
    logic [7:0] hold_bits_q;
    logic       deq_s;

    assign deq_s = hold_valid_q && io_deq_ready;

    // Single holding register; a byte arriving while it is occupied and not draining is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_bits_q  <= 8'h00;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (deliver_q) begin
                if (!hold_valid_q || deq_s) begin
                    hold_bits_q  <= shift_q;
                    hold_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (deq_s) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign io_deq_valid = hold_valid_q;
    assign io_deq_bits  = hold_bits_q;
`endif

    assign io_frame_err = frame_err_q;
    assign io_overrun   = overrun_q;
    assign io_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at BAUD_DIV = 16; compile with UART_RX_FIFO_EN to check the FIFO build.
module tb_uart_rx_core;

    localparam int BDIV = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       io_rx;
    logic       io_deq_valid;
    logic       io_deq_ready;
    logic [7:0] io_deq_bits;
    logic       io_frame_err;
    logic       io_overrun;
    logic       io_busy;

    uart_rx_core #(
        .CLOCK_FREQ(1_600_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .io_rx       (io_rx),
        .io_deq_valid(io_deq_valid),
        .io_deq_ready(io_deq_ready),
        .io_deq_bits (io_deq_bits),
        .io_frame_err(io_frame_err),
        .io_overrun  (io_overrun),
        .io_busy     (io_busy)
    );

    always #5 clock = ~clock;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_err = 0;
    int         rx_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         vhigh_cnt = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] rx_log [256];
    logic       tog_en = 1'b0;
    int         tog_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor on the falling edge: handshakes, pulses and the valid rising edge.
    always @(negedge clock) begin
        prev_valid <= io_deq_valid;
        if (io_deq_valid && !prev_valid) rise_cyc <= cyc;
        if (io_deq_valid) vhigh_cnt <= vhigh_cnt + 1;
        if (io_deq_valid && io_deq_ready) begin
            rx_log[rx_cnt[7:0]] <= io_deq_bits;
            rx_cnt <= rx_cnt + 1;
        end
        if (io_frame_err) ferr_cnt <= ferr_cnt + 1;
        if (io_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        io_rx = b;
        for (int k = 0; k < BDIV; k++) begin
            @(posedge clock);
            #1;
            if (tog_en) begin
                tog_cnt++;
                if (tog_cnt == 3) begin
                    tog_cnt = 0;
                    io_deq_ready = !io_deq_ready;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_byte;
        int         exp_fe;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [$];
    int         s_rx, s_fe, s_ov, s_vh, e0, g0, fall;
    logic       saw_busy, rst_busy, rst_valid;
    logic [7:0] rb;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_n: 1, exp_byte: 8'h00, exp_fe: 0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_n: 1, exp_byte: 8'hFF, exp_fe: 0};
        vecs[2] = '{data: 8'h80, stop: 1'b1, exp_n: 1, exp_byte: 8'h80, exp_fe: 0};
        vecs[3] = '{data: 8'h01, stop: 1'b1, exp_n: 1, exp_byte: 8'h01, exp_fe: 0};
        vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_n: 0, exp_byte: 8'h00, exp_fe: 1};
        vecs[5] = '{data: 8'h5A, stop: 1'b1, exp_n: 1, exp_byte: 8'h5A, exp_fe: 0};

        io_rx = 1'b1;
        io_deq_ready = 1'b1;
        reset_n = 1'b0;
        wait_cycles(4);
        check("reset_valid", int'(io_deq_valid), 0);
        check("reset_bits", int'(io_deq_bits), 0);
        check("reset_frame_err", int'(io_frame_err), 0);
        check("reset_overrun", int'(io_overrun), 0);
        check("reset_busy", int'(io_busy), 0);
        reset_n = 1'b1;
        wait_cycles(2 * BDIV);

        // Single byte: latency, one-cycle valid, no framing error
        s_rx = rx_cnt; s_vh = vhigh_cnt; s_fe = ferr_cnt;
        e0 = cyc + 1;
        send_frame(8'h55, 1'b1);
        io_rx = 1'b1;
        wait_cycles(2 * BDIV);
        check("b55_count", rx_cnt - s_rx, 1);
        rb = rx_log[s_rx[7:0]];
        check("b55_data", int'(rb), 8'h55);
        check_range("b55_latency", rise_cyc - e0, 154, 157);
        check("b55_valid_cycles", vhigh_cnt - s_vh, 1);
        check("b55_frame_err", ferr_cnt - s_fe, 0);

        // Table of frames, consumer always ready
        for (int v = 0; v < 6; v++) begin
            s_rx = rx_cnt; s_fe = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            io_rx = 1'b1;
            wait_cycles(2 * BDIV);
            check($sformatf("vec%0d_count", v), rx_cnt - s_rx, vecs[v].exp_n);
            check($sformatf("vec%0d_frame_err", v), ferr_cnt - s_fe, vecs[v].exp_fe);
            if (vecs[v].exp_n == 1) begin
                rb = rx_log[s_rx[7:0]];
                check($sformatf("vec%0d_data", v), int'(rb), int'(vecs[v].exp_byte));
            end
        end

        // Back-to-back frames with consumer stalled
        io_deq_ready = 1'b0;
        s_rx = rx_cnt; s_ov = ovr_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        io_rx = 1'b1;
        wait_cycles(2 * BDIV);
        check("stall_valid", int'(io_deq_valid), 1);
        check("stall_head", int'(io_deq_bits), 8'hA3);
`ifdef UART_RX_FIFO_EN
        check("stall_overrun", ovr_cnt - s_ov, 0);
        io_deq_ready = 1'b1;
        wait_cycles(4);
        check("stall_drain_count", rx_cnt - s_rx, 2);
        rb = rx_log[s_rx[7:0]];
        check("stall_first", int'(rb), 8'hA3);
        rb = rx_log[(s_rx + 1) & 255];
        check("stall_second", int'(rb), 8'h3C);
`else
        check("stall_overrun", ovr_cnt - s_ov, 1);
        io_deq_ready = 1'b1;
        wait_cycles(4);
        check("stall_drain_count", rx_cnt - s_rx, 1);
        rb = rx_log[s_rx[7:0]];
        check("stall_first", int'(rb), 8'hA3);
`endif
        check("stall_empty", int'(io_deq_valid), 0);

        // Four-cycle low glitch
        s_rx = rx_cnt; s_fe = ferr_cnt;
        g0 = cyc + 1;
        io_rx = 1'b0;
        wait_cycles(4);
        io_rx = 1'b1;
        saw_busy = 1'b0;
        fall = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (io_busy) saw_busy = 1'b1;
            else if (saw_busy && fall < 0) fall = cyc;
        end
        @(posedge clock);
        #1;
        check("glitch_busy_seen", int'(saw_busy), 1);
        check_range("glitch_busy_fall", fall - g0, 0, 12);
        check("glitch_count", rx_cnt - s_rx, 0);
        check("glitch_frame_err", ferr_cnt - s_fe, 0);

        // Bad stop bit, line held low, then a clean frame
        s_rx = rx_cnt; s_fe = ferr_cnt;
        send_frame(8'h41, 1'b0);
        io_rx = 1'b0;
        wait_cycles(3 * BDIV);
        io_rx = 1'b1;
        wait_cycles(2 * BDIV);
        send_frame(8'h42, 1'b1);
        io_rx = 1'b1;
        wait_cycles(2 * BDIV);
        check("ferr_pulses", ferr_cnt - s_fe, 1);
        check("ferr_count", rx_cnt - s_rx, 1);
        rb = rx_log[s_rx[7:0]];
        check("ferr_recover_data", int'(rb), 8'h42);

        // Reset pulse during data bit 3
        s_rx = rx_cnt; s_fe = ferr_cnt;
        rst_busy = 1'b1;
        rst_valid = 1'b1;
        fork
            send_frame(8'hF8, 1'b1);
            begin
                wait_cycles(4 * BDIV + BDIV / 2);
                reset_n = 1'b0;
                wait_cycles(2);
                rst_busy = io_busy;
                rst_valid = io_deq_valid;
                wait_cycles(3);
                reset_n = 1'b1;
            end
        join
        io_rx = 1'b1;
        wait_cycles(2 * BDIV);
        check("midrst_busy", int'(rst_busy), 0);
        check("midrst_valid", int'(rst_valid), 0);
        check("midrst_nothing", rx_cnt - s_rx, 0);
        send_frame(8'h7E, 1'b1);
        io_rx = 1'b1;
        wait_cycles(2 * BDIV);
        check("midrst_count", rx_cnt - s_rx, 1);
        rb = rx_log[s_rx[7:0]];
        check("midrst_data", int'(rb), 8'h7E);
        check("midrst_frame_err", ferr_cnt - s_fe, 0);

        // Random back-to-back stream with ready toggling every 3 cycles
        s_rx = rx_cnt; s_ov = ovr_cnt;
        tog_cnt = 0;
        tog_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        tog_en = 1'b0;
        io_rx = 1'b1;
        io_deq_ready = 1'b1;
        wait_cycles(3 * BDIV);
        check("stream_count", rx_cnt - s_rx, 16);
        check("stream_overrun", ovr_cnt - s_ov, 0);
        for (int i = 0; i < 16; i++) begin
            rb = rx_log[(s_rx + i) & 255];
            check($sformatf("stream_byte%0d", i), int'(rb), int'(exp_q[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Synthesizable UART receiver that the SoC uses on the console RX pin. It is the hardware end of the simulation UART console's transmit path.
- Line format: 8N1, LSB first, idle high.
- Deframes bytes and presents them on a valid/ready dequeue port to the MMIO UART wrapper.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
CLOCK_FREQ, 100_000_000, core clock frequency in Hz.
BAUD_RATE, 115_200, line baud rate.
BAUD_DIV, CLOCK_FREQ/BAUD_RATE (integer truncation), clock cycles per bit. Must be >= 4.
FIFO_DEPTH, 4, receive FIFO entries, power of 2, >= 2. Used only when UART_RX_FIFO_EN is defined.

Ports:
clock  input  1  core clock, all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
io_rx  input  1  serial line from pad or sim console, asynchronous to clock.
io_deq_valid  output  1  received byte available.
io_deq_ready  input  1  consumer accepts byte; transfer occurs when valid && ready at a rising edge.
io_deq_bits  output  8  received byte.
io_frame_err  output  1  one-cycle pulse: stop bit sampled low.
io_overrun  output  1  one-cycle pulse: completed byte dropped because storage is full.
io_busy  output  1  high in START, DATA or STOP.

Behaviour:
- Interface: one clock (clock); reset_n is asynchronous, active-low.
- Synchronizer:
  - 2-flop synchronizer on io_rx, both flops reset to 1.
  - Output rx_s is used exclusively; io_rx is never read directly.
- Reset:
  - state = WAIT_IDLE; baud counter = 0; bit index = 0; shift register = 0.
  - io_deq_valid = 0, io_deq_bits = 0, io_frame_err = 0, io_overrun = 0, io_busy = 0.
  - Asserting reset mid-frame discards the partial byte immediately.
- Baud counter: width clog2(BAUD_DIV); cleared on every state transition.
- States:
  - WAIT_IDLE: go to IDLE when rx_s == 1. Prevents a false start when reset releases mid-frame or during a break.
  - IDLE: rx_s == 0 -> START.
  - START:
    - Count to BAUD_DIV/2 - 1, then sample.
    - rx_s == 0 -> DATA with bit index 0.
    - rx_s == 1 -> IDLE. This is a glitch: no error is flagged.
  - DATA:
    - Count to BAUD_DIV - 1, then shift rx_s into the MSB (shift right) and increment the bit index.
    - After bit index 7 is sampled -> STOP.
  - STOP: count to BAUD_DIV - 1, then sample.
    - rx_s == 1: deliver byte -> IDLE.
    - rx_s == 0: pulse io_frame_err, discard byte -> WAIT_IDLE.
- Delivery, single holding register:
  - If valid == 0, or valid && ready in the same cycle: load the byte and set valid in the following cycle. No overrun.
  - Otherwise: pulse io_overrun and drop the new byte. The held byte is unchanged.
- Dequeue: valid && ready with no concurrent delivery clears valid. io_deq_bits holds its last value while valid == 0.
- Latency: io_deq_valid rises between 9.5*BAUD_DIV + 2 and 9.5*BAUD_DIV + 5 cycles after the first clock edge that sees io_rx low.
- Frame timing: back-to-back frames with a 1-bit stop are supported. IDLE is re-entered half a bit before the line's next start edge.

Optional Feature:
UART_RX_FIFO_EN
- Defined:
  - Holding register replaced by a FIFO_DEPTH-entry circular FIFO. Read and write pointers carry one extra wrap bit.
  - io_deq_bits is driven from the head entry; io_deq_valid = !empty.
  - Overrun pulses only when the FIFO is full and no dequeue happens in the same cycle.
  - Simultaneous enqueue and dequeue on a full FIFO succeeds.
  - Ports are unchanged.
- Undefined: single holding register as described above.

Test Plan:
- Setup for all scenarios: CLOCK_FREQ=1_600_000, BAUD_RATE=100_000, so BAUD_DIV=16.
- Idle line, reset released, io_deq_ready=1: send 0x55 -> io_deq_bits=0x55 with valid high for exactly one cycle. Valid rises within 154..157 cycles of the start edge. io_frame_err=0.
- io_deq_ready=0: send 0xA3 then 0x3C back-to-back.
  - Without FIFO: 0xA3 is held and io_overrun pulses once at the end of the second frame.
  - With FIFO: both bytes are dequeued in order and there is no overrun.
- Low glitch of 4 cycles on io_rx -> no valid, no io_frame_err; state returns to IDLE and io_busy falls within 12 cycles.
- Frame 0x41 with stop bit forced low, then line held low for 3 bit times, then 0x42 sent normally -> one io_frame_err pulse, 0x41 not delivered, then 0x42 delivered.
- reset_n asserted for 5 cycles during data bit 3 of a frame, released while the line is still mid-frame -> no byte delivered from that frame. The next clean frame 0x7E is received correctly.
- Streaming 16 random bytes with io_deq_ready toggling every 3 cycles -> all bytes received in order. With UART_RX_FIFO_EN there are zero overruns.
